ov7642_capture: RTL and testbench

//  Receive side of the OV7642 parallel camera interface: samples vsync/href/data on pclk,

---
 rtl/ov7642_capture_if.sv | 17 +
 rtl/ov7642_capture.sv | 249 ++++++++++++++++++++++++
 tb/tb_ov7642_capture.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7642_capture_if.sv
// ov7642_capture_if
//   Pixel stream leaving the OV7642 capture block.
//   m_valid  pixel valid (master -> slave)
//   m_ready  downstream accepts the pixel when m_valid && m_ready (slave -> master)
//   m_data   Y pixel
//   m_sof    first pixel of frame (row 0, col 0)
//   m_eol    last pixel of a line (col WIDTH-1)
interface ov7642_capture_if;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       m_sof;
   logic       m_eol;

   modport master (output m_valid, m_data, m_sof, m_eol, input  m_ready);
   modport slave  (input  m_valid, m_data, m_sof, m_eol, output m_ready);
endinterface

// File: rtl/ov7642_capture.sv
// ov7642_capture
//   Receive side of the OV7642 parallel camera bus. Samples vsync/href/data on
//   pclk, syncs to frames on the falling edge of vsync, keeps the Y bytes of the
//   "Y dummy Y dummy" line format, buffers them in a small FIFO and presents
//   them on a valid/ready stream tagged with start-of-frame / end-of-line.
//   Frame and line geometry problems are reported on the status outputs.
//
// Ports
//   pclk        pixel clock (camera launches on negedge, sampled here on posedge)
//   rst         asynchronous reset, active high
//   enable      capture enable, only looked at when a frame would start
//   vsync       frame sync, high during the inter-frame gap
//   href        line valid
//   data        camera byte bus
//   pix         output pixel stream (master side of ov7642_capture_if)
//   frame_done  1-cycle pulse when a captured frame ends (vsync rise)
//   frame_err   sticky frame geometry error, cleared when the next frame starts
//   line_err    1-cycle pulse on a malformed or aborted line
//   overflow    sticky until reset: a Y byte was lost because the FIFO was full
//   frame_cnt   completed frames since reset, wraps
module ov7642_capture #(
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             enable,
   input  logic             vsync,
   input  logic             href,
   input  logic [7:0]       data,
   ov7642_capture_if.master pix,
   output logic             frame_done,
   output logic             frame_err,
   output logic             line_err,
   output logic             overflow,
   output logic [15:0]      frame_cnt
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = $clog2(HEIGHT + 1);
   localparam int BW = $clog2(2 * WIDTH + 2);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] COL_MAX    = CW'(WIDTH);
   localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX    = RW'(HEIGHT);
   localparam logic [BW-1:0] LINE_BYTES = BW'(2 * WIDTH);
   // byte counter parks one above a legal line so long lines stay "wrong"
   localparam logic [BW-1:0] BYTE_SAT   = BW'(2 * WIDTH + 1);
   localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

   typedef struct packed {
      logic       sof;
      logic       eol;
      logic [7:0] y;
   } pix_t;

   // ------------------------------------------------------------------
   // Input stage: one register (S1) plus a delayed copy for edge detects
   // ------------------------------------------------------------------
   logic       s1_vsync, s1_href;
   logic [7:0] s1_data;
   logic       s2_vsync, s2_href;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         s1_vsync <= 1'b0;
         s1_href  <= 1'b0;
         s1_data  <= 8'h00;
         s2_vsync <= 1'b0;
         s2_href  <= 1'b0;
      end else begin
         s1_vsync <= vsync;
         s1_href  <= href;
         s1_data  <= data;
         s2_vsync <= s1_vsync;
         s2_href  <= s1_href;
      end
   end

   logic vs_rise, vs_fall, hr_rise, hr_fall;
   assign vs_rise = s1_vsync & ~s2_vsync;
   assign vs_fall = ~s1_vsync & s2_vsync;
   assign hr_rise = s1_href & ~s2_href;
   assign hr_fall = ~s1_href & s2_href;

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t         state, state_nxt;
   logic [RW-1:0]  row;
   logic [CW-1:0]  col;
   logic           phase;        // 0: Y byte, 1: dummy byte
   logic [BW-1:0]  byte_cnt;

   logic start, byte_en, line_end, push, set_ferr;
   logic line_err_nxt, frame_done_nxt;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      start          = 1'b0;
      byte_en        = 1'b0;
      line_end       = 1'b0;
      push           = 1'b0;
      set_ferr       = 1'b0;
      line_err_nxt   = 1'b0;
      frame_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (vs_fall && enable) begin
               state_nxt = ACTIVE;
               start     = 1'b1;
            end
         end
         ACTIVE: begin
            if (vs_rise) begin
               // vsync wins over any byte still on the bus: a line that is
               // still open here is aborted without its EOL
               state_nxt      = BLANK;
               frame_done_nxt = 1'b1;
               if (s1_href)        line_err_nxt = 1'b1;
               if (row != ROW_MAX) set_ferr     = 1'b1;
            end else if (s1_href) begin
               byte_en = 1'b1;
               if (!phase && col < COL_MAX && row < ROW_MAX) push = 1'b1;
               if (hr_rise && row >= ROW_MAX)                 set_ferr = 1'b1;
            end else if (hr_fall) begin
               line_end = 1'b1;
               if (byte_cnt != LINE_BYTES) begin
                  line_err_nxt = 1'b1;
                  set_ferr     = 1'b1;
               end
            end
         end
         BLANK: begin
            if (vs_fall) begin
               if (enable) begin
                  state_nxt = ACTIVE;
                  start     = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // geometry counters and status flags
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         row        <= '0;
         col        <= '0;
         phase      <= 1'b0;
         byte_cnt   <= '0;
         frame_err  <= 1'b0;
         line_err   <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= 16'h0000;
      end else begin
         line_err   <= line_err_nxt;
         frame_done <= frame_done_nxt;
         if (frame_done_nxt) frame_cnt <= frame_cnt + 16'd1;

         if (start) begin
            row       <= '0;
            col       <= '0;
            phase     <= 1'b0;
            byte_cnt  <= '0;
            frame_err <= 1'b0;
         end else begin
            if (set_ferr) frame_err <= 1'b1;
            if (line_end) begin
               // row saturates at HEIGHT; surplus lines are still flagged on href rise
               if (row < ROW_MAX) row <= row + RW'(1);
               col      <= '0;
               phase    <= 1'b0;
               byte_cnt <= '0;
            end else if (byte_en) begin
               phase <= ~phase;
               if (!phase && col < COL_MAX) col <= col + CW'(1);
               if (byte_cnt != BYTE_SAT)    byte_cnt <= byte_cnt + BW'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Output FIFO
   //   m_valid is registered from the occupancy left after this cycle's pop,
   //   so a freshly written entry into an empty FIFO shows up one edge later.
   //   The head entry is read straight from storage, which keeps the total
   //   capacity at exactly FIFO_DEPTH.
   // ------------------------------------------------------------------
   pix_t           fifo_mem [FIFO_DEPTH];
   pix_t           wr_pix, head;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           vld_q;
   logic           pop, full, wr_en, drop;

   always_comb begin
      wr_pix     = '0;
      wr_pix.sof = (row == '0) && (col == '0);
      wr_pix.eol = (col == COL_LAST);
      wr_pix.y   = s1_data;
   end

   assign pop   = vld_q & pix.m_ready;
   assign full  = (count == FULL_CNT);
   assign wr_en = push & (~full | pop);   // push+pop when full is lossless
   assign drop  = push & full & ~pop;

   always_ff @(posedge pclk) begin
      if (wr_en) fifo_mem[wr_ptr] <= wr_pix;
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         vld_q    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
         vld_q <= (count != (AW + 1)'(pop));
         if (drop) overflow <= 1'b1;
      end
   end

   // outputs forced to 0 while empty so reset leaves the whole bus quiet
   assign head        = fifo_mem[rd_ptr];
   assign pix.m_valid = vld_q;
   assign pix.m_data  = vld_q ? head.y   : 8'h00;
   assign pix.m_sof   = vld_q ? head.sof : 1'b0;
   assign pix.m_eol   = vld_q ? head.eol : 1'b0;

endmodule

// File: tb/tb_ov7642_capture.sv
module tb_ov7642_capture;
   localparam int W = 4;
   localparam int H = 2;
   localparam int D = 4;

   logic        pclk = 1'b0;
   logic        rst, enable, vsync, href;
   logic [7:0]  data;
   logic        frame_done, frame_err, line_err, overflow;
   logic [15:0] frame_cnt;

   ov7642_capture_if pix ();

   ov7642_capture #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
      .pclk       (pclk),
      .rst        (rst),
      .enable     (enable),
      .vsync      (vsync),
      .href       (href),
      .data       (data),
      .pix        (pix),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .line_err   (line_err),
      .overflow   (overflow),
      .frame_cnt  (frame_cnt)
   );

   always #5 pclk = ~pclk;

   int vectors = 0;
   int errors  = 0;

   // accepted pixels as {sof, eol, y} and pulse counts, sampled mid-cycle
   logic [9:0] got [$];
   int line_err_seen   = 0;
   int frame_done_seen = 0;

   always @(negedge pclk) begin
      #3;
      if (pix.m_valid && pix.m_ready) got.push_back({pix.m_sof, pix.m_eol, pix.m_data});
      if (line_err)   line_err_seen++;
      if (frame_done) frame_done_seen++;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic clear_mon();
      got.delete();
      line_err_seen   = 0;
      frame_done_seen = 0;
   endtask

   // n bytes of "Y dummy" with Y = base, base+1, ...; optionally close the line
   task automatic send_bytes(input int n, input logic [7:0] base, input bit end_line);
      for (int k = 0; k < n; k++) begin
         @(negedge pclk);
         href = 1'b1;
         data = k[0] ? 8'hFF : base + 8'(k / 2);
      end
      if (end_line) begin
         @(negedge pclk);
         href = 1'b0;
         data = 8'h00;
         cycles(4);
      end
   endtask

   task automatic vsync_rise();
      @(negedge pclk);
      vsync = 1'b1;
      cycles(3);
   endtask

   task automatic vsync_fall();
      @(negedge pclk);
      vsync = 1'b0;
      cycles(3);
   endtask

   task automatic test_reset();
      cycles(2);
      vectors++; if (pix.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", pix.m_valid); end
      vectors++; if (pix.m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", pix.m_data); end
      vectors++; if ({frame_done, frame_err, line_err, overflow} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", {frame_done, frame_err, line_err, overflow}); end
      vectors++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
      @(negedge pclk);
      rst    = 1'b0;
      enable = 1'b1;
      cycles(2);
   endtask

   task automatic test_no_sync();
      clear_mon();
      send_bytes(8, 8'hA0, 1);
      send_bytes(8, 8'hA4, 1);
      vectors++; if (got.size() != 0) begin errors++; $display("FAIL nosync_pixels: got %0d expected 0", got.size()); end
      vectors++; if (pix.m_valid !== 1'b0) begin errors++; $display("FAIL nosync_m_valid: got %b expected 0", pix.m_valid); end
      vectors++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL nosync_frame_cnt: got %0d expected 0", frame_cnt); end
   endtask

   // one clean 2-line frame starting from IDLE, including the latency check
   task automatic test_basic(input logic [7:0] base);
      logic [9:0] exp;
      clear_mon();
      vsync_rise();
      vsync_fall();
      fork
         send_bytes(8, base, 1);
         begin
            @(negedge pclk);
            @(posedge pclk);            // first Y sampled here
            @(posedge pclk); #1;        // written into FIFO
            vectors++; if (pix.m_valid !== 1'b0) begin errors++; $display("FAIL latency_n1: got %b expected 0", pix.m_valid); end
            @(posedge pclk); #1;
            vectors++; if (pix.m_valid !== 1'b1) begin errors++; $display("FAIL latency_n2: got %b expected 1", pix.m_valid); end
         end
      join
      send_bytes(8, base + 8'd4, 1);
      vsync_rise();
      vectors++; if (got.size() != 8) begin errors++; $display("FAIL basic_count: got %0d expected 8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         exp = {(i == 0), (i == 3 || i == 7), base + 8'(i)};
         vectors++; if (got[i] !== exp) begin errors++; $display("FAIL basic_pix%0d: got %h expected %h", i, got[i], exp); end
      end
      vectors++; if (frame_done_seen != 1) begin errors++; $display("FAIL basic_frame_done: got %0d expected 1", frame_done_seen); end
      vectors++; if (line_err_seen != 0) begin errors++; $display("FAIL basic_line_err: got %0d expected 0", line_err_seen); end
      vectors++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt); end
      vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b expected 0", frame_err); end
      vsync_fall();
   endtask

   task automatic test_short_line();
      logic [9:0] exp;
      clear_mon();
      send_bytes(6, 8'h20, 1);
      vectors++; if (line_err_seen != 1) begin errors++; $display("FAIL short_line_err: got %0d expected 1", line_err_seen); end
      vectors++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_frame_err: got %b expected 1", frame_err); end
      send_bytes(8, 8'h30, 1);
      vsync_rise();
      vectors++; if (got.size() != 7) begin errors++; $display("FAIL short_count: got %0d expected 7", got.size()); end
      for (int i = 0; i < 7 && i < got.size(); i++) begin
         exp = (i < 3) ? {(i == 0), 1'b0, 8'h20 + 8'(i)} : {1'b0, (i == 6), 8'h30 + 8'(i - 3)};
         vectors++; if (got[i] !== exp) begin errors++; $display("FAIL short_pix%0d: got %h expected %h", i, got[i], exp); end
      end
      vectors++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_err_held: got %b expected 1", frame_err); end
      vectors++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL short_frame_cnt: got %0d expected 2", frame_cnt); end
      vsync_fall();
      vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_err_clear: got %b expected 0", frame_err); end
   endtask

   task automatic test_overflow();
      logic [9:0] exp;
      clear_mon();
      pix.m_ready = 1'b0;
      send_bytes(8, 8'h40, 1);
      send_bytes(8, 8'h50, 1);
      vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      vectors++; if ({pix.m_valid, pix.m_sof, pix.m_data} !== {2'b11, 8'h40}) begin
         errors++; $display("FAIL ovf_held: got %b/%b/%h expected 1/1/40", pix.m_valid, pix.m_sof, pix.m_data); end
      vectors++; if (got.size() != 0) begin errors++; $display("FAIL ovf_no_pop: got %0d expected 0", got.size()); end
      vsync_rise();
      vsync_fall();
      @(negedge pclk);
      pix.m_ready = 1'b1;
      cycles(8);
      vectors++; if (got.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         exp = {(i == 0), (i == 3), 8'h40 + 8'(i)};
         vectors++; if (got[i] !== exp) begin errors++; $display("FAIL ovf_pix%0d: got %h expected %h", i, got[i], exp); end
      end
      vectors++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL ovf_frame_cnt: got %0d expected 3", frame_cnt); end
   endtask

   task automatic test_vsync_abort();
      logic [9:0] exp;
      clear_mon();
      send_bytes(8, 8'h60, 1);
      send_bytes(4, 8'h70, 0);
      @(negedge pclk);
      vsync = 1'b1;
      data  = 8'h72;                   // would be a Y byte, must not be kept
      cycles(3);
      @(negedge pclk);
      href = 1'b0;
      data = 8'h00;
      cycles(4);
      vectors++; if (line_err_seen != 1) begin errors++; $display("FAIL abort_line_err: got %0d expected 1", line_err_seen); end
      vectors++; if (frame_done_seen != 1) begin errors++; $display("FAIL abort_frame_done: got %0d expected 1", frame_done_seen); end
      vectors++; if (frame_err !== 1'b1) begin errors++; $display("FAIL abort_frame_err: got %b expected 1", frame_err); end
      vectors++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL abort_frame_cnt: got %0d expected 4", frame_cnt); end
      vectors++; if (got.size() != 6) begin errors++; $display("FAIL abort_count: got %0d expected 6", got.size()); end
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         exp = (i < 4) ? {(i == 0), (i == 3), 8'h60 + 8'(i)} : {2'b00, 8'h70 + 8'(i - 4)};
         vectors++; if (got[i] !== exp) begin errors++; $display("FAIL abort_pix%0d: got %h expected %h", i, got[i], exp); end
      end
   endtask

   task automatic test_reset_mid();
      vsync_fall();
      clear_mon();
      pix.m_ready = 1'b0;
      send_bytes(6, 8'h80, 0);
      cycles(2);
      vectors++; if ({pix.m_valid, pix.m_data} !== {1'b1, 8'h80}) begin
         errors++; $display("FAIL rstmid_pre: got %b/%h expected 1/80", pix.m_valid, pix.m_data); end
      #2;
      rst = 1'b1;
      #1;
      vectors++; if ({pix.m_valid, pix.m_data} !== {1'b0, 8'h00}) begin
         errors++; $display("FAIL rstmid_m_valid: got %b/%h expected 0/00", pix.m_valid, pix.m_data); end
      vectors++; if ({frame_done, frame_err, line_err, overflow} !== 4'b0000) begin
         errors++; $display("FAIL rstmid_flags: got %b expected 0000", {frame_done, frame_err, line_err, overflow}); end
      vectors++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_frame_cnt: got %0d expected 0", frame_cnt); end
      @(negedge pclk);
      href        = 1'b0;
      data        = 8'h00;
      pix.m_ready = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(2);
      test_basic(8'h90);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
      pix.m_ready = 1'b1;
      test_reset();
      test_no_sync();
      test_basic(8'h10);
      test_short_line();
      test_overflow();
      test_vsync_abort();
      test_reset_mid();
      cycles(4);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time %0t exceeded limit 100000", $time);
      $fatal(1);
   end
endmodule
